copperv_bus_arbiter: RTL and testbench
======================================

// Module: copperv_bus_arbiter
// PURPOSE
//  Merges the copperv instruction (i_*) and data (d_*) bus masters onto a single memory port (m_*).
//  Sits directly downstream of the copperv core and upstream of the memory/peripheral slave.
//  Reads and writes are arbitrated independently, each with round-robin priority.
//  One read and one write may be in flight at a time; each is routed back to its owner.
//  All channels use valid/ready handshakes. A transfer occurs on a cycle where valid & ready are both high.
// PARAMETERS
//  bus_width  32  width of every address and data bus
// PORTS
//  clk                                   in   1    clock, rising edge
//  rst                                   in   1    asynchronous reset, active-low
//  {i,d}_raddr_valid, {i,d}_waddr_valid  in   1    master read/write address valid
//  {i,d}_wdata_valid, {i,d}_rdata_ready  in   1    master write data valid, read data ready
//  {i,d}_raddr, {i,d}_waddr, {i,d}_wdata in   bus_width  master address/data
//  {i,d}_raddr_ready, {i,d}_waddr_ready  out  1    accept pulse towards master
//  {i,d}_wdata_ready, {i,d}_rdata_valid  out  1    accept pulse; read data valid to owner
//  {i,d}_rdata                           out  bus_width  read data (= m_rdata, both masters)
//  m_raddr_valid, m_waddr_valid, m_wdata_valid, m_rdata_ready  out  1  towards slave
//  m_raddr, m_waddr, m_wdata             out  bus_width  registered address/data to slave
//  m_raddr_ready, m_waddr_ready, m_wdata_ready, m_rdata_valid  in  1  from slave
//  m_rdata                               in   bus_width  slave read data
// BEHAVIOUR
//  Reset (rst=0, async):
//   - read FSM enters R_IDLE; write FSM enters W_IDLE.
//   - Every *_valid and *_ready output is 0; m_raddr, m_waddr and m_wdata are 0.
//   - Both round-robin pointers favour d.
//   - An in-flight transaction is dropped with no response. The slave must be reset together with this block.
//  Read FSM (R_IDLE -> R_ADDR -> R_DATA -> R_IDLE):
//   - R_IDLE: requesters are masters with raddr_valid=1.
//     - Grant per the pointer when both request, else the sole requester.
//     - Same cycle: x_raddr_ready=1 (combinational) for the winner only.
//     - Latch x_raddr into m_raddr, record owner, flip pointer to the other master, go to R_ADDR.
//   - R_ADDR: m_raddr_valid=1 and m_raddr held stable. On m_raddr_ready, go to R_DATA.
//   - R_DATA: combinational pass-through.
//     - owner_rdata_valid = m_rdata_valid; m_rdata_ready = owner_rdata_ready.
//     - Non-owner rdata_valid=0.
//     - On m_rdata_valid & m_rdata_ready, go to R_IDLE.
//   - All x_raddr_ready are 0 outside R_IDLE.
//   - Minimum latency: master handshake at cycle N; m_raddr_valid at N+1; earliest rdata at N+2.
//   - Back-to-back reads: the next grant is possible in the cycle after the rdata handshake.
//  Write FSM (W_IDLE -> W_XFER -> W_IDLE), independent of the read FSM:
//   - W_IDLE: a master requests only when x_waddr_valid & x_wdata_valid are both 1.
//     - Grant by the write pointer.
//     - Winner gets x_waddr_ready=1 and x_wdata_ready=1 in the same cycle.
//     - Latch m_waddr and m_wdata, set pending flags aw_pend=1 and w_pend=1, flip pointer, go to W_XFER.
//   - W_XFER: m_waddr_valid=aw_pend and m_wdata_valid=w_pend.
//     - Each flag clears on its own slave handshake.
//     - Both handshakes in the same cycle are legal.
//     - When both flags are clear (next-state), go to W_IDLE.
//   - x_waddr_ready and x_wdata_ready are 0 outside W_IDLE.
//  Simultaneous events:
//   - A read and a write may be accepted in the same cycle from the same or different masters.
//   - No read/write ordering is enforced; masters needing ordering must wait for completion.
//   - A master raising only one of waddr_valid/wdata_valid is never granted (it waits).
//  Arbitration fairness: with both masters requesting continuously, grants strictly alternate.
//  m_rdata is forwarded unmodified to both i_rdata and d_rdata. Only valid is gated.
// STRUCTURE
//  Package copperv_bus_pkg:
//   - read state encodings R_IDLE/R_ADDR/R_DATA and write state encodings W_IDLE/W_XFER.
//   - master ids MST_I=0 and MST_D=1.
//  Sub-module copperv_rr_arb2, instantiated twice (read, write):
//   - inputs: req[1:0], advance.
//   - outputs: one-hot gnt[1:0], winner id.
//   - the pointer updates on advance and resets to favour MST_D.
// TESTING
//  1. i read i_raddr=0x100 at cycle 0:
//     i_raddr_ready=1 at cycle 0; m_raddr=0x100 with valid at cycle 1.
//     Slave returns 0xDEADBEEF: i_rdata_valid=1 and d_rdata_valid=0.
//  2. i and d reads both requested from reset:
//     d granted first, i second; a third contention is granted to d.
//     With continuous requests, grants alternate.
//  3. d write waddr=0x200, wdata=0x55:
//     both readies in the same cycle; slave accepts waddr at +1 and wdata at +3.
//     W_IDLE is reached after the wdata handshake; the next write is accepted one cycle later.
//  4. d write and i read issued in the same cycle:
//     both accepted that cycle; each completes independently with correct routing.
//  5. Backpressure: d_rdata_ready=0 for 4 cycles during R_DATA.
//     m_rdata_ready=0 throughout; the transfer completes on the cycle d_rdata_ready rises.
//  6. rst=0 for 1 cycle while in R_DATA and W_XFER:
//     all valids drop immediately; a subsequent i read of 0x300 completes normally.

Source files
------------

// File: rtl/copperv_bus_arbiter_pkg.sv
// Shared encodings for the copperv bus arbiter: FSM states and master ids.
package copperv_bus_pkg;

  typedef logic mst_t;

  localparam mst_t MST_I = 1'b0;
  localparam mst_t MST_D = 1'b1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_XFER = 1'b1;

  function automatic mst_t other_mst(input mst_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/copperv_bus_arbiter_if.sv
// One copperv bus port: read address, read data, write address and write data channels.
interface copperv_bus_arbiter_if #(
  parameter int bus_width = 32
);
  logic                 raddr_valid;
  logic                 raddr_ready;
  logic [bus_width-1:0] raddr;
  logic                 rdata_valid;
  logic                 rdata_ready;
  logic [bus_width-1:0] rdata;
  logic                 waddr_valid;
  logic                 waddr_ready;
  logic [bus_width-1:0] waddr;
  logic                 wdata_valid;
  logic                 wdata_ready;
  logic [bus_width-1:0] wdata;

  // master issues requests, slave answers them
  modport master (
    output raddr_valid, raddr, rdata_ready, waddr_valid, waddr, wdata_valid, wdata,
    input  raddr_ready, rdata_valid, rdata, waddr_ready, wdata_ready
  );
  modport slave (
    input  raddr_valid, raddr, rdata_ready, waddr_valid, waddr, wdata_valid, wdata,
    output raddr_ready, rdata_valid, rdata, waddr_ready, wdata_ready
  );
endinterface

// File: rtl/copperv_bus_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves past the winner on each accepted grant.
module copperv_rr_arb2
  import copperv_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output mst_t       winner
);

  mst_t ptr_reg;

  always_comb begin
    if (req[MST_I] && req[MST_D]) begin
      winner = ptr_reg;
    end else begin
      winner = req[MST_D] ? MST_D : MST_I;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] && (winner == mst_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= MST_D;
    end else if (advance) begin
      ptr_reg <= other_mst(winner);
    end
  end

endmodule

// File: rtl/copperv_bus_arbiter.sv
// Merges the copperv instruction and data masters onto one memory port; reads and writes arbitrate independently.
module copperv_bus_arbiter
  import copperv_bus_pkg::*;
#(
  parameter int bus_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  copperv_bus_arbiter_if.slave  i_bus,
  copperv_bus_arbiter_if.slave  d_bus,
  copperv_bus_arbiter_if.master m_bus
);

  logic [1:0]           rd_state_reg, rd_state_next;
  mst_t                 rd_owner_reg;
  logic [bus_width-1:0] m_raddr_reg;
  logic [1:0]           rd_req, rd_gnt;
  mst_t                 rd_winner;
  logic                 rd_advance;
  logic                 rd_data_phase;

  logic [0:0]           wr_state_reg, wr_state_next;
  logic                 aw_pend_reg, aw_pend_next;
  logic                 w_pend_reg, w_pend_next;
  logic [bus_width-1:0] m_waddr_reg, m_wdata_reg;
  logic [1:0]           wr_req, wr_gnt;
  mst_t                 wr_winner;
  logic                 wr_advance;

  // Requests only count while idle and out of reset, so every ready output is low in reset.
  assign rd_req     = {d_bus.raddr_valid, i_bus.raddr_valid} & {2{rst && (rd_state_reg == R_IDLE)}};
  assign rd_advance = |rd_req;

  copperv_rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .advance (rd_advance),
    .gnt     (rd_gnt),
    .winner  (rd_winner)
  );

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (rd_advance) rd_state_next = R_ADDR;
      R_ADDR:  if (m_bus.raddr_ready) rd_state_next = R_DATA;
      R_DATA:  if (m_bus.rdata_valid && m_bus.rdata_ready) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_reg <= R_IDLE;
      rd_owner_reg <= MST_I;
      m_raddr_reg  <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (rd_advance) begin
        rd_owner_reg <= rd_winner;
        m_raddr_reg  <= (rd_winner == MST_D) ? d_bus.raddr : i_bus.raddr;
      end
    end
  end

  assign rd_data_phase     = (rd_state_reg == R_DATA);
  assign i_bus.raddr_ready = rd_gnt[MST_I];
  assign d_bus.raddr_ready = rd_gnt[MST_D];
  assign m_bus.raddr_valid = (rd_state_reg == R_ADDR);
  assign m_bus.raddr       = m_raddr_reg;
  assign i_bus.rdata_valid = rd_data_phase && (rd_owner_reg == MST_I) && m_bus.rdata_valid;
  assign d_bus.rdata_valid = rd_data_phase && (rd_owner_reg == MST_D) && m_bus.rdata_valid;
  assign m_bus.rdata_ready = rd_data_phase &&
                             ((rd_owner_reg == MST_D) ? d_bus.rdata_ready : i_bus.rdata_ready);
  assign i_bus.rdata       = m_bus.rdata;
  assign d_bus.rdata       = m_bus.rdata;

  // A write is only eligible once its master presents address and data together.
  assign wr_req = {d_bus.waddr_valid && d_bus.wdata_valid,
                   i_bus.waddr_valid && i_bus.wdata_valid} & {2{rst && (wr_state_reg == W_IDLE)}};
  assign wr_advance = |wr_req;

  copperv_rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (wr_advance),
    .gnt     (wr_gnt),
    .winner  (wr_winner)
  );

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_pend_next  = aw_pend_reg;
    w_pend_next   = w_pend_reg;
    if (wr_state_reg == W_IDLE) begin
      if (wr_advance) begin
        wr_state_next = W_XFER;
        aw_pend_next  = 1'b1;
        w_pend_next   = 1'b1;
      end
    end else begin
      aw_pend_next = aw_pend_reg && !m_bus.waddr_ready;
      w_pend_next  = w_pend_reg && !m_bus.wdata_ready;
      if (!aw_pend_next && !w_pend_next) wr_state_next = W_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_reg <= W_IDLE;
      aw_pend_reg  <= 1'b0;
      w_pend_reg   <= 1'b0;
      m_waddr_reg  <= '0;
      m_wdata_reg  <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_pend_reg  <= aw_pend_next;
      w_pend_reg   <= w_pend_next;
      if (wr_advance) begin
        m_waddr_reg <= (wr_winner == MST_D) ? d_bus.waddr : i_bus.waddr;
        m_wdata_reg <= (wr_winner == MST_D) ? d_bus.wdata : i_bus.wdata;
      end
    end
  end

  assign i_bus.waddr_ready = wr_gnt[MST_I];
  assign i_bus.wdata_ready = wr_gnt[MST_I];
  assign d_bus.waddr_ready = wr_gnt[MST_D];
  assign d_bus.wdata_ready = wr_gnt[MST_D];
  assign m_bus.waddr_valid = (wr_state_reg == W_XFER) && aw_pend_reg;
  assign m_bus.wdata_valid = (wr_state_reg == W_XFER) && w_pend_reg;
  assign m_bus.waddr       = m_waddr_reg;
  assign m_bus.wdata       = m_wdata_reg;

endmodule

// File: tb/tb_copperv_bus_arbiter.sv
// Random masters and slave around the arbiter; a transaction-level model feeds queues that a monitor drains.
module tb_copperv_bus_arbiter;
  import copperv_bus_pkg::*;

  localparam int BW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  copperv_bus_arbiter_if #(.bus_width(BW)) i_bus ();
  copperv_bus_arbiter_if #(.bus_width(BW)) d_bus ();
  copperv_bus_arbiter_if #(.bus_width(BW)) m_bus ();

  copperv_bus_arbiter #(.bus_width(BW)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        own;
    logic [31:0] data;
  } rd_exp_t;

  // expected responses, pushed by the model and drained by the monitor
  logic        q_rgnt[$];
  logic        q_wgnt[$];
  logic [31:0] q_ar[$];
  logic [31:0] q_aw[$];
  logic [31:0] q_w[$];
  rd_exp_t     q_rd[$];

  // master stimulus state, index 0 = i, 1 = d
  bit          rpend[2];
  logic [31:0] raddr_v[2];
  bit          rready[2];
  bit          wpend[2];
  bit          wa_v[2];
  bit          wd_v[2];
  logic [31:0] wa[2];
  logic [31:0] wd[2];

  // transaction-level model: who last won each channel and what is outstanding
  bit rd_busy, rd_in_data, rd_last, rd_owner;
  bit wr_busy, aw_left, w_left, wr_last;

  task automatic model_reset();
    rd_busy = 0; rd_in_data = 0; rd_last = MST_I; rd_owner = MST_I;
    wr_busy = 0; aw_left = 0; w_left = 0; wr_last = MST_I;
    for (int m = 0; m < 2; m++) begin
      rpend[m] = 0; wpend[m] = 0; wa_v[m] = 0; wd_v[m] = 0; rready[m] = 0;
      raddr_v[m] = '0; wa[m] = '0; wd[m] = '0;
    end
    q_rgnt.delete(); q_wgnt.delete(); q_ar.delete(); q_aw.delete(); q_w.delete(); q_rd.delete();
  endtask

  task automatic drive_masters();
    i_bus.raddr_valid = rpend[0];           i_bus.raddr = raddr_v[0];
    d_bus.raddr_valid = rpend[1];           d_bus.raddr = raddr_v[1];
    i_bus.rdata_ready = rready[0];          d_bus.rdata_ready = rready[1];
    i_bus.waddr_valid = wpend[0] && wa_v[0]; i_bus.waddr = wa[0];
    i_bus.wdata_valid = wpend[0] && wd_v[0]; i_bus.wdata = wd[0];
    d_bus.waddr_valid = wpend[1] && wa_v[1]; d_bus.waddr = wa[1];
    d_bus.wdata_valid = wpend[1] && wd_v[1]; d_bus.wdata = wd[1];
  endtask

  task automatic drive_slave(input bit ar, input bit rv, input logic [31:0] rd, input bit aw, input bit w);
    m_bus.raddr_ready = ar;
    m_bus.rdata_valid = rv;
    m_bus.rdata       = rd;
    m_bus.waddr_ready = aw;
    m_bus.wdata_ready = w;
  endtask

  // One clock of stimulus plus the model's prediction of what that cycle's edge accepts.
  task automatic step(input bit allow_new, input bit force_both);
    bit          s_ar, s_rv, s_aw, s_w, win;
    logic [31:0] s_rd;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rpend[m] && allow_new && (force_both || $urandom_range(0, 1) == 1)) begin
        rpend[m]   = 1;
        raddr_v[m] = $urandom & 32'hFFFF_FFFC;
      end
      if (!wpend[m] && allow_new && (force_both || $urandom_range(0, 2) == 0)) begin
        wpend[m] = 1;
        wa[m]    = $urandom & 32'hFFFF_FFFC;
        wd[m]    = $urandom;
        wa_v[m]  = force_both || ($urandom_range(0, 1) == 1);
        wd_v[m]  = force_both || !wa_v[m] || ($urandom_range(0, 1) == 1);
      end else if (wpend[m]) begin
        if (!wa_v[m] && $urandom_range(0, 1) == 1) wa_v[m] = 1;
        if (!wd_v[m] && $urandom_range(0, 1) == 1) wd_v[m] = 1;
      end
      rready[m] = ($urandom_range(0, 3) != 0);
    end
    s_ar = ($urandom_range(0, 1) == 1);
    s_rv = ($urandom_range(0, 1) == 1);
    s_rd = $urandom;
    s_aw = ($urandom_range(0, 1) == 1);
    s_w  = ($urandom_range(0, 1) == 1);
    drive_masters();
    drive_slave(s_ar, s_rv, s_rd, s_aw, s_w);

    if (!rd_busy) begin
      if (rpend[0] || rpend[1]) begin
        win = (rpend[0] && rpend[1]) ? !rd_last : rpend[1];
        q_rgnt.push_back(win);
        q_ar.push_back(raddr_v[win]);
        rd_owner = win; rd_last = win; rd_busy = 1; rd_in_data = 0;
        rpend[win] = 0;
      end
    end else if (!rd_in_data) begin
      if (s_ar) rd_in_data = 1;
    end else if (s_rv && rready[rd_owner]) begin
      q_rd.push_back('{own: rd_owner, data: s_rd});
      rd_busy = 0;
    end

    if (!wr_busy) begin
      bit req_i, req_d;
      req_i = wpend[0] && wa_v[0] && wd_v[0];
      req_d = wpend[1] && wa_v[1] && wd_v[1];
      if (req_i || req_d) begin
        win = (req_i && req_d) ? !wr_last : req_d;
        q_wgnt.push_back(win);
        q_aw.push_back(wa[win]);
        q_w.push_back(wd[win]);
        wr_last = win; wr_busy = 1; aw_left = 1; w_left = 1;
        wpend[win] = 0; wa_v[win] = 0; wd_v[win] = 0;
      end
    end else begin
      if (aw_left && s_aw) aw_left = 0;
      if (w_left && s_w) w_left = 0;
      if (!aw_left && !w_left) wr_busy = 0;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid_ready"},
          {i_bus.raddr_ready, d_bus.raddr_ready, i_bus.waddr_ready, d_bus.waddr_ready,
           i_bus.wdata_ready, d_bus.wdata_ready, i_bus.rdata_valid, d_bus.rdata_valid,
           m_bus.raddr_valid, m_bus.waddr_valid, m_bus.wdata_valid, m_bus.rdata_ready}, 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or handshake.
  initial begin
    forever begin
      logic [1:0]  rg, wa_r, wd_r;
      logic        e;
      rd_exp_t     er;
      @(negedge clk);
      #2;
      if (rst) begin
        rg   = {d_bus.raddr_ready, i_bus.raddr_ready};
        wa_r = {d_bus.waddr_ready, i_bus.waddr_ready};
        wd_r = {d_bus.wdata_ready, i_bus.wdata_ready};
        if (q_rgnt.size() > 0) begin
          e = q_rgnt.pop_front();
          check("rd_grant", rg, e ? 32'd2 : 32'd1);
        end else if (rg != 2'b00) begin
          check("rd_grant_spurious", rg, 32'd0);
        end
        if (q_wgnt.size() > 0) begin
          e = q_wgnt.pop_front();
          check("wr_grant", {wa_r, wd_r}, e ? 32'hA : 32'h5);
        end else if ((wa_r | wd_r) != 2'b00) begin
          check("wr_grant_spurious", {wa_r, wd_r}, 32'd0);
        end
        if (m_bus.raddr_valid && m_bus.raddr_ready) begin
          if (q_ar.size() == 0) check("m_raddr_unexpected", 32'd1, 32'd0);
          else check("m_raddr", m_bus.raddr, q_ar.pop_front());
        end
        if (m_bus.waddr_valid && m_bus.waddr_ready) begin
          if (q_aw.size() == 0) check("m_waddr_unexpected", 32'd1, 32'd0);
          else check("m_waddr", m_bus.waddr, q_aw.pop_front());
          $display("write addr 0x%08h", m_bus.waddr);
        end
        if (m_bus.wdata_valid && m_bus.wdata_ready) begin
          if (q_w.size() == 0) check("m_wdata_unexpected", 32'd1, 32'd0);
          else check("m_wdata", m_bus.wdata, q_w.pop_front());
          $display("write data 0x%08h", m_bus.wdata);
        end
        if (i_bus.rdata_valid && d_bus.rdata_valid) check("rd_valid_onehot", 32'd3, 32'd1);
        if ((i_bus.rdata_valid && i_bus.rdata_ready) || (d_bus.rdata_valid && d_bus.rdata_ready)) begin
          if (q_rd.size() == 0) begin
            check("rdata_unexpected", 32'd1, 32'd0);
          end else begin
            er = q_rd.pop_front();
            check("rd_owner", d_bus.rdata_valid, er.own);
            check("rd_data", er.own ? d_bus.rdata : i_bus.rdata, er.data);
            check("m_rdata_ready", m_bus.rdata_ready, 32'd1);
            $display("read  owner=%s data=0x%08h", er.own ? "d" : "i", er.data);
          end
        end
      end
    end
  end

  initial begin
    int tries;
    model_reset();
    // hold reset with masters and slave all asserting, to show nothing leaks through
    for (int m = 0; m < 2; m++) begin
      rpend[m] = 1; wpend[m] = 1; wa_v[m] = 1; wd_v[m] = 1; rready[m] = 1;
    end
    drive_masters();
    drive_slave(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_m_raddr", m_bus.raddr, 32'd0);
    check("reset_m_waddr", m_bus.waddr, 32'd0);
    check("reset_m_wdata", m_bus.wdata, 32'd0);
    model_reset();
    drive_masters();
    drive_slave(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // contention straight out of reset must favour d on both channels
    step(1'b1, 1'b1);
    for (int c = 0; c < 1500; c++) step(1'b1, 1'b0);

    // reset mid-flight: wait for a read data phase overlapping a pending write
    tries = 0;
    while (!(rd_busy && rd_in_data && wr_busy) && tries < 300) begin
      step(1'b1, 1'b0);
      tries++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("midrst");
    model_reset();
    drive_masters();
    drive_slave(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // a plain i read of 0x300 after the reset, then more random traffic
    @(negedge clk);
    rpend[0] = 1; raddr_v[0] = 32'h0000_0300;
    q_rgnt.push_back(MST_I);
    q_ar.push_back(32'h0000_0300);
    drive_masters();
    rd_busy = 1; rd_in_data = 0; rd_owner = MST_I; rd_last = MST_I; rpend[0] = 0;
    for (int c = 0; c < 800; c++) step(1'b1, 1'b0);
    for (int c = 0; c < 150; c++) step(1'b0, 1'b0);

    @(negedge clk);
    #3;
    check("drain_rd_busy", {rd_busy, wr_busy}, 32'd0);
    check("drain_queues", q_ar.size() + q_aw.size() + q_w.size() + q_rd.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
